mesh_sort_checker: RTL and testbench
====================================

Name: mesh_sort_checker

Overview:
- Synthesizable, parametrised result checker for the shear-sort mesh.
- Watches the per-PE `nanci_result` words of an N-node mesh after a sort is launched.
- Declares pass when every node holds its expected `{flag, addr, data}` word, stable for a programmable number of cycles. Declares fail on timeout.
- Replaces fixed-delay checks. Used both in benches and on-chip as a BIST monitor.

Parameters:
- N, 16, number of mesh nodes.
- ADDR_WIDTH, 4, address field width; must be >= clog2(N).
- DATA_WIDTH, 32, data field width.
- DESCEND, 1, 1: node k expects data N-1-k; 0: node k expects data k.
- MIN_CYCLES, 21, cycles after start before comparisons may count toward pass (nominal sort latency).
- STABLE_CYCLES, 4, consecutive all-match cycles required for pass; must be >= 1.
- TIMEOUT, 200, cycle count at which an unfinished check fails; must be > MIN_CYCLES+STABLE_CYCLES.
- CNT_WIDTH, 16, cycle counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a check.
- result_flat  in  N*(ADDR_WIDTH+DATA_WIDTH+1)  node k occupies bits [(k+1)*W1-1 : k*W1], where W1=ADDR_WIDTH+DATA_WIDTH+1; each field is {flag, addr, data}.
- busy  out  1  high while a check is running.
- done  out  1  high from completion until next start or rst.
- pass  out  1  valid when done; 1 = sorted and stable.
- mismatch_mask  out  N  bit k set when node k mismatched on the last registered compare.
- first_bad_idx  out  ADDR_WIDTH  lowest set index of mismatch_mask; 0 when mask is all zero.
- cycle_count  out  CNT_WIDTH  cycles since start; frozen at completion.

Behaviour:
- Expected word for node k: flag=0, addr=k[ADDR_WIDTH-1:0], data=(DESCEND ? N-1-k : k) truncated to DATA_WIDTH.
- Compare uses case-inequality semantics: any X/Z bit on an input counts as a mismatch in simulation.
- Reset values: state=IDLE; busy, done, pass = 0; mismatch_mask=0; first_bad_idx=0; cycle_count=0; internal stable counter=0.
- IDLE: outputs hold. On start: go to RUN, clear cycle_count, stable counter, mask, done and pass.
- RUN, every cycle:
  - cycle_count increments by 1.
  - mismatch_mask is registered from the current result_flat, so it carries one cycle of latency.
  - Once cycle_count >= MIN_CYCLES: if the registered mask is all zero, the stable counter increments; otherwise it clears.
  - Before MIN_CYCLES the stable counter stays 0.
- RUN to DONE with pass=1 when the stable counter reaches STABLE_CYCLES.
- RUN to DONE with pass=0 when cycle_count reaches TIMEOUT.
- If the pass and timeout conditions occur in the same cycle, pass wins.
- DONE:
  - done=1, busy=0.
  - mismatch_mask, first_bad_idx and cycle_count are frozen at the values from the completing cycle.
  - start returns to RUN with all counters cleared.
- start asserted during RUN restarts the check: counters and mask clear, state stays RUN, done stays 0.
- rst at any point, including mid-RUN, returns all state to reset values on that edge; rst has priority over start.
- busy = (state==RUN), registered. done and busy are never both high.
- first_bad_idx is a combinational priority encode of the registered mask and is frozen along with it.
- A mismatch after pass is not monitored. Checking ends at DONE.

Test Plan:
- N=16, DESCEND=1: drive node k={0,k,15-k} from cycle 21 onward, pulse start -> done=1, pass=1 with cycle_count=26 (registered-mask latency plus STABLE_CYCLES=4); mismatch_mask=0.
- Nodes 5 and 9 hold wrong data forever -> done at cycle_count=200 with pass=0, mismatch_mask=0x0220, first_bad_idx=5.
- Correct values present, but node 3 flag=1 for one cycle at cycle 23 -> stable counter resets, pass asserts 4 cycles after the glitch clears; cycle_count exceeds the clean-case value by the glitch offset.
- Node 0 input is X -> mismatch bit 0 set; timeout gives pass=0, first_bad_idx=0, mask=0x0001.
- rst asserted at cycle 10 of RUN -> next edge: busy=0, done=0, cycle_count=0. A start mid-RUN resets cycle_count to 0, with done staying low.
- DESCEND=0, N=8, ADDR_WIDTH=3: node k={0,k,k} -> pass=1. The same stimulus with DESCEND=1 -> timeout, mask=0xFF except nodes where k==7-k (none), i.e. 0xFF.

Source files
------------

// File: rtl/mesh_sort_checker.sv
// Result checker for the shear-sort mesh. Compares every node's {flag, addr, data}
// word against the expected sorted order. Declares pass after STABLE_CYCLES
// consecutive all-match cycles past MIN_CYCLES, and fail once TIMEOUT is reached.
module mesh_sort_checker #(
  parameter int N             = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter bit DESCEND       = 1'b1,
  parameter int MIN_CYCLES    = 21,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 200,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0]  result_flat,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    pass,
  output logic [N-1:0]                            mismatch_mask,
  output logic [ADDR_WIDTH-1:0]                   first_bad_idx,
  output logic [CNT_WIDTH-1:0]                    cycle_count
);

  localparam int W1 = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [SW-1:0]        stable;
  logic [SW-1:0]        stable_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [N-1:0]         cur_mis;

  // Per-node compare; case inequality so X/Z on an input counts as a mismatch.
  for (genvar k = 0; k < N; k++) begin : g_cmp
    localparam logic [W1-1:0] EXP = {1'b0, ADDR_WIDTH'(k),
                                     DATA_WIDTH'(DESCEND ? (N - 1 - k) : k)};
    assign cur_mis[k] = (result_flat[k*W1 +: W1] !== EXP);
  end

  assign cnt_nxt = cycle_count + CNT_WIDTH'(1);

  // Stable-run counter: only counts once the nominal sort latency has elapsed.
  always_comb begin
    stable_nxt = '0;
    if (cycle_count >= CNT_WIDTH'(MIN_CYCLES)) begin
      if (mismatch_mask == '0) stable_nxt = stable + SW'(1);
      else                     stable_nxt = '0;
    end
  end

  // Lowest mismatching node index from the registered mask.
  always_comb begin
    first_bad_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mismatch_mask[i]) first_bad_idx = ADDR_WIDTH'(i);
  end

  // Check FSM: start (re)launches from any state, pass beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      cycle_count   <= '0;
      stable        <= '0;
    end else if (start) begin
      state         <= S_RUN;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= '0;
      cycle_count   <= '0;
      stable        <= '0;
    end else if (state == S_RUN) begin
      cycle_count   <= cnt_nxt;
      mismatch_mask <= cur_mis;
      stable        <= stable_nxt;
      if (stable_nxt == SW'(STABLE_CYCLES)) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (cnt_nxt >= CNT_WIDTH'(TIMEOUT)) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mesh_sort_checker.sv
// Directed bench for mesh_sort_checker: a 16-node descending instance plus two
// 8-node instances (ascending / descending) driven with the same ascending data.
module tb_mesh_sort_checker;

  logic clk = 1'b0;
  logic rst, start, start8;
  logic [16*37-1:0] res16;
  logic [8*36-1:0]  res8;

  logic        busy16, done16, pass16;
  logic [15:0] mask16;
  logic [3:0]  idx16;
  logic [15:0] cnt16;

  logic        busy_a, done_a, pass_a, busy_c, done_c, pass_c;
  logic [7:0]  mask_a, mask_c;
  logic [2:0]  idx_a, idx_c;
  logic [15:0] cnt_a, cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mesh_sort_checker dut16 (
    .clk(clk), .rst(rst), .start(start), .result_flat(res16),
    .busy(busy16), .done(done16), .pass(pass16), .mismatch_mask(mask16),
    .first_bad_idx(idx16), .cycle_count(cnt16));

  mesh_sort_checker #(.N(8), .ADDR_WIDTH(3), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start8), .result_flat(res8),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_mask(mask_a),
    .first_bad_idx(idx_a), .cycle_count(cnt_a));

  mesh_sort_checker #(.N(8), .ADDR_WIDTH(3), .DESCEND(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start8), .result_flat(res8),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_mask(mask_c),
    .first_bad_idx(idx_c), .cycle_count(cnt_c));

  function automatic logic [16*37-1:0] good16();
    logic [16*37-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*37 +: 37] = {1'b0, 4'(k), 32'(15 - k)};
    return v;
  endfunction

  function automatic logic [8*36-1:0] asc8();
    logic [8*36-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*36 +: 36] = {1'b0, 3'(k), 32'(k)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done16(input string tag);
    for (int i = 0; i < 300 && !done16; i++) @(negedge clk);
    chk(tag, 64'(done16), 64'd1);
  endtask

  initial begin
    logic [16*37-1:0] v;
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    res16 = '0; res8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy16), 64'd0);
    chk("rst_done",  64'(done16), 64'd0);
    chk("rst_pass",  64'(pass16), 64'd0);
    chk("rst_mask",  64'(mask16), 64'd0);
    chk("rst_idx",   64'(idx16),  64'd0);
    chk("rst_cnt",   64'(cnt16),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean sort: correct data appears when cycle_count reaches 21.
    res16 = '0;
    pulse_start();
    chk("run_busy", 64'(busy16), 64'd1);
    chk("run_done", 64'(done16), 64'd0);
    repeat (21) @(negedge clk);
    chk("clean_cnt21", 64'(cnt16), 64'd21);
    res16 = good16();
    wait_done16("clean_done");
    chk("clean_pass", 64'(pass16), 64'd1);
    chk("clean_cnt",  64'(cnt16),  64'd26);
    chk("clean_mask", 64'(mask16), 64'd0);
    chk("clean_busy", 64'(busy16), 64'd0);

    // Nodes 5 and 9 wrong forever -> timeout.
    v = good16();
    v[5*37] = ~v[5*37];
    v[9*37] = ~v[9*37];
    res16 = v;
    pulse_start();
    wait_done16("to_done");
    chk("to_pass", 64'(pass16), 64'd0);
    chk("to_cnt",  64'(cnt16),  64'd200);
    chk("to_mask", 64'(mask16), 64'h0220);
    chk("to_idx",  64'(idx16),  64'd5);
    repeat (3) @(negedge clk);
    chk("to_frozen_cnt",  64'(cnt16),  64'd200);
    chk("to_frozen_done", 64'(done16), 64'd1);

    // One-cycle flag glitch on node 3 while cycle_count == 23.
    res16 = '0;
    pulse_start();
    repeat (21) @(negedge clk);
    res16 = good16();
    repeat (2) @(negedge clk);
    chk("gl_cnt23", 64'(cnt16), 64'd23);
    v = good16();
    v[3*37 + 36] = 1'b1;
    res16 = v;
    @(negedge clk);
    res16 = good16();
    wait_done16("gl_done");
    chk("gl_pass", 64'(pass16), 64'd1);
    chk("gl_cnt",  64'(cnt16),  64'd29);

    // Unknown value on node 0.
    v = good16();
    v[36:0] = 'x;
    res16 = v;
    pulse_start();
    wait_done16("x_done");
    chk("x_pass", 64'(pass16), 64'd0);
    chk("x_mask", 64'(mask16), 64'h0001);
    chk("x_idx",  64'(idx16),  64'd0);

    // Reset mid-run, then restart mid-run.
    res16 = '0;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("mr_cnt10", 64'(cnt16), 64'd10);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("mr_busy", 64'(busy16), 64'd0);
    chk("mr_done", 64'(done16), 64'd0);
    chk("mr_cnt",  64'(cnt16),  64'd0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("rs_cnt5", 64'(cnt16), 64'd5);
    pulse_start();
    chk("rs_cnt",  64'(cnt16),  64'd0);
    chk("rs_done", 64'(done16), 64'd0);
    chk("rs_busy", 64'(busy16), 64'd1);

    // 8-node ascending data: ascending checker passes, descending one times out.
    res8 = asc8();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 300 && !(done_a && done_c); i++) @(negedge clk);
    chk("a_done", 64'(done_a), 64'd1);
    chk("a_pass", 64'(pass_a), 64'd1);
    chk("a_cnt",  64'(cnt_a),  64'd25);
    chk("a_mask", 64'(mask_a), 64'd0);
    chk("c_done", 64'(done_c), 64'd1);
    chk("c_pass", 64'(pass_c), 64'd0);
    chk("c_cnt",  64'(cnt_c),  64'd200);
    chk("c_mask", 64'(mask_c), 64'hFF);
    chk("c_idx",  64'(idx_c),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
